// File: rtl/capture_sequencer.sv
// capture_sequencer: end-of-frame .. reset phase sequencer for N_CAM imagers on the PCIe clock.
// Optional watchdog on the waiting states is compiled in by defining CAPTURE_SEQ_WATCHDOG_EN.
module capture_sequencer #(
    parameter int N_CAM            = 2,
    parameter int REF_CAM          = 0,
    parameter int DRAIN_CYCLES     = 256,
    parameter int META_WAIT_CYCLES = 32,
    parameter int RST_CYCLES       = 16,
    parameter int CNT_W            = 10,
    parameter int TO_W             = 24
) (
    input  logic             c,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             continuous,
    input  logic [N_CAM-1:0] cam_mask,
    input  logic [N_CAM-1:0] fv,
    input  logic             metadata_flush_complete,
    input  logic             dma_flush_complete,
    output logic [N_CAM-1:0] cap_en,
    output logic             metadata_en,
    output logic             metadata_flush,
    output logic             dma_flush,
    output logic             cap_rst,
    output logic             irq_set,
    output logic             busy,
    output logic             timeout,
    output logic             aborted,
    output logic [15:0]      frame_cnt,
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_EOF       = 4'd1,
        S_SOF       = 4'd2,
        S_IMAGE     = 4'd3,
        S_DRAIN     = 4'd4,
        S_META      = 4'd5,
        S_META_WAIT = 4'd6,
        S_DMA_FLUSH = 4'd7,
        S_RST       = 4'd8
    } state_t;

    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] MW_LAST    = CNT_W'(META_WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYCLES - 1);

    if (REF_CAM < 0 || REF_CAM >= N_CAM) begin : g_bad_ref_cam
        $error("REF_CAM must index an existing camera");
    end
    if (TO_W < 2 || CNT_W < 1) begin : g_bad_widths
        $error("TO_W must be at least 2 and CNT_W at least 1");
    end

    state_t           st_q, st_d;
    logic [CNT_W-1:0] dwell_q;
    logic [N_CAM-1:0] m_q;
    logic             all_low;
    logic             sof_ref;
    logic             ref_found;
    logic             leave_idle;
    logic             abort_now;
    logic             rst_exit;
    logic             rst_exit_q;
    logic             rst_ok_q;
    logic             wd_fire;

    assign state   = st_q;
    assign busy    = (st_q != S_IDLE);
    assign all_low = ~|(fv & m_q);

    // Start-of-frame follows REF_CAM, or the lowest enabled camera when REF_CAM is masked off.
    always_comb begin
        sof_ref   = fv[REF_CAM];
        ref_found = 1'b0;
        if (!m_q[REF_CAM]) begin
            sof_ref = 1'b0;
            for (int i = 0; i < N_CAM; i++) begin
                if (m_q[i] && !ref_found) begin
                    sof_ref   = fv[i];
                    ref_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        st_d       = st_q;
        leave_idle = 1'b0;
        abort_now  = 1'b0;
        rst_exit   = 1'b0;
        case (st_q)
            S_IDLE: begin
                if (start && !stop && (|cam_mask)) begin
                    st_d       = S_EOF;
                    leave_idle = 1'b1;
                end
            end
            S_EOF:       if (all_low) st_d = S_SOF;
            S_SOF:       if (sof_ref) st_d = S_IMAGE;
            S_IMAGE:     if (all_low) st_d = S_DRAIN;
            S_DRAIN:     if (dwell_q == DRAIN_LAST) st_d = S_META;
            S_META:      if (metadata_flush_complete) st_d = S_META_WAIT;
            S_META_WAIT: if (dwell_q == MW_LAST) st_d = S_DMA_FLUSH;
            S_DMA_FLUSH: if (dma_flush_complete) st_d = S_RST;
            S_RST: begin
                if (dwell_q == RST_LAST) begin
                    rst_exit = 1'b1;
                    st_d     = (continuous && !stop && !timeout && !aborted) ? S_EOF : S_IDLE;
                end
            end
            default:     st_d = S_IDLE;
        endcase
        // Flushes already in flight (META, DMA_FLUSH) and RST itself are never cut short by stop.
        if (stop && (st_q == S_EOF || st_q == S_SOF || st_q == S_IMAGE ||
                     st_q == S_DRAIN || st_q == S_META_WAIT)) begin
            st_d      = S_RST;
            abort_now = 1'b1;
        end
        if (wd_fire) st_d = S_RST;
    end

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            st_q       <= S_IDLE;
            dwell_q    <= '0;
            m_q        <= '0;
            aborted    <= 1'b0;
            rst_exit_q <= 1'b0;
            rst_ok_q   <= 1'b0;
        end else begin
            st_q       <= st_d;
            dwell_q    <= (st_d != st_q) ? '0 : dwell_q + 1'b1;
            rst_exit_q <= rst_exit;
            rst_ok_q   <= !aborted && !timeout;
            if (leave_idle) begin
                m_q     <= cam_mask;
                aborted <= 1'b0;
            end else if (abort_now) begin
                aborted <= 1'b1;
            end
        end
    end

    // Moore decodes of the state register, one cycle behind state entry.
    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            cap_en         <= '0;
            metadata_en    <= 1'b0;
            metadata_flush <= 1'b0;
            dma_flush      <= 1'b0;
            cap_rst        <= 1'b0;
            irq_set        <= 1'b0;
            frame_cnt      <= '0;
        end else begin
            cap_en         <= (st_q == S_SOF || st_q == S_IMAGE) ? m_q : '0;
            metadata_en    <= (st_q == S_DRAIN || st_q == S_META || st_q == S_META_WAIT);
            metadata_flush <= (st_q == S_META) && (dwell_q == '0);
            dma_flush      <= (st_q == S_DMA_FLUSH);
            cap_rst        <= (st_q == S_RST);
            irq_set        <= rst_exit_q;
            if (rst_exit_q && rst_ok_q) frame_cnt <= frame_cnt + 16'd1;
        end
    end

`ifdef CAPTURE_SEQ_WATCHDOG_EN
    localparam logic [TO_W-1:0] WD_LAST = ~TO_W'(1);

    logic [TO_W-1:0] wd_q;
    logic            wd_active;
    logic            timeout_q;

    assign wd_active = (st_q == S_EOF || st_q == S_SOF || st_q == S_IMAGE ||
                        st_q == S_META || st_q == S_DMA_FLUSH);
    // Fires on the edge that would take the counter to all-ones, so RST is entered on that edge.
    assign wd_fire   = wd_active && (wd_q == WD_LAST);
    assign timeout   = timeout_q;

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (st_d != st_q)   wd_q <= '0;
            else if (wd_active) wd_q <= wd_q + 1'b1;
            if (leave_idle)     timeout_q <= 1'b0;
            else if (wd_fire)   timeout_q <= 1'b1;
        end
    end
`else
    assign wd_fire = 1'b0;
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer: single frame, continuous with abort, masked reference
// camera, empty mask, async reset during DMA flush, and the watchdog when it is compiled in.
module tb_capture_sequencer;

    localparam int N_CAM = 2;
    localparam logic [3:0] S_IDLE = 4'd0, S_EOF = 4'd1, S_SOF = 4'd2, S_IMAGE = 4'd3,
                           S_DRAIN = 4'd4, S_META = 4'd5, S_META_WAIT = 4'd6,
                           S_DMA_FLUSH = 4'd7, S_RST = 4'd8;

    logic             c;
    logic             rst_n;
    logic             start;
    logic             stop;
    logic             continuous;
    logic [N_CAM-1:0] cam_mask;
    logic [N_CAM-1:0] fv;
    logic             metadata_flush_complete;
    logic             dma_flush_complete;
    logic [N_CAM-1:0] cap_en;
    logic             metadata_en;
    logic             metadata_flush;
    logic             dma_flush;
    logic             cap_rst;
    logic             irq_set;
    logic             busy;
    logic             timeout;
    logic             aborted;
    logic [15:0]      frame_cnt;
    logic [3:0]       state;

    capture_sequencer #(
        .N_CAM(N_CAM), .REF_CAM(0), .DRAIN_CYCLES(4), .META_WAIT_CYCLES(3),
        .RST_CYCLES(2), .CNT_W(4), .TO_W(8)
    ) dut (
        .c(c), .rst_n(rst_n), .start(start), .stop(stop), .continuous(continuous),
        .cam_mask(cam_mask), .fv(fv),
        .metadata_flush_complete(metadata_flush_complete),
        .dma_flush_complete(dma_flush_complete),
        .cap_en(cap_en), .metadata_en(metadata_en), .metadata_flush(metadata_flush),
        .dma_flush(dma_flush), .cap_rst(cap_rst), .irq_set(irq_set), .busy(busy),
        .timeout(timeout), .aborted(aborted), .frame_cnt(frame_cnt), .state(state)
    );

    // ---------------- clock / global time limit ----------------
    initial c = 1'b0;
    always #5 c = ~c;

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation still running, required finished");
        $fatal(1, "time limit");
    end

    // ---------------- monitor ----------------
    int          n_vec = 0;
    int          n_err = 0;
    logic        clr_mon = 1'b0;
    logic [N_CAM-1:0] exp_mask = '0;
    logic [3:0]  last_st, prev_st;
    logic [63:0] seq_acc;
    int          run, irq_cnt, mf_cnt, df_cyc, cr_cyc, me_cyc, busy_cyc, cap_err;
    int          dur [16];

    always @(negedge c) begin
        if (clr_mon) begin
            last_st  <= state;
            prev_st  <= state;
            run      <= 1;
            seq_acc  <= '0;
            irq_cnt  <= 0;
            mf_cnt   <= 0;
            df_cyc   <= 0;
            cr_cyc   <= 0;
            me_cyc   <= 0;
            busy_cyc <= 0;
            cap_err  <= 0;
            for (int i = 0; i < 16; i++) dur[i] <= 0;
        end else begin
            if (state != last_st) begin
                dur[last_st] <= run;
                run          <= 1;
                seq_acc      <= {seq_acc[59:0], state};
                last_st      <= state;
            end else begin
                run <= run + 1;
            end
            irq_cnt  <= irq_cnt + int'(irq_set);
            mf_cnt   <= mf_cnt + int'(metadata_flush);
            df_cyc   <= df_cyc + int'(dma_flush);
            cr_cyc   <= cr_cyc + int'(cap_rst);
            me_cyc   <= me_cyc + int'(metadata_en);
            busy_cyc <= busy_cyc + int'(busy);
            // cap_en reflects the state held one cycle earlier
            if (cap_en !== ((prev_st == S_SOF || prev_st == S_IMAGE) ? exp_mask : '0))
                cap_err <= cap_err + 1;
            prev_st <= state;
        end
    end

    // ---------------- checking / driver tasks ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge c);
            #1;
        end
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget, input string tag);
        int k;
        k = 0;
        while (state !== s && k < budget) begin
            tick(1);
            k++;
        end
        check_eq(tag, 32'(state), 32'(s));
    endtask

    task automatic clear_mon();
        clr_mon = 1'b1;
        @(negedge c);
        #1;
        clr_mon = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        continuous = 1'b0;
        fv = '0;
        cam_mask = '0;
        metadata_flush_complete = 1'b1;
        dma_flush_complete = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    function automatic logic [31:0] out_vec();
        return 32'({cap_en, metadata_en, metadata_flush, dma_flush, cap_rst, irq_set,
                    busy, timeout, aborted, frame_cnt});
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        continuous = 1'b0;
        fv = '0;
        cam_mask = '0;
        metadata_flush_complete = 1'b1;
        dma_flush_complete = 1'b1;
        #12;
        check_eq("reset_state", 32'(state), 32'(S_IDLE));
        check_eq("reset_outputs", out_vec(), 32'h0);
        rst_n = 1'b1;
        tick(1);

        // single frame, both cameras, EOF held off by a still-active camera
        exp_mask = 2'b11;
        cam_mask = 2'b11;
        fv = 2'b01;
        clear_mon();
        start = 1'b1;
        wait_state(S_EOF, 5, "t1_enter_eof");
        start = 1'b0;
        tick(3);
        check_eq("t1_eof_hold", 32'(state), 32'(S_EOF));
        fv = 2'b00;
        wait_state(S_SOF, 3, "t1_enter_sof");
        tick(2);
        check_eq("t1_sof_hold", 32'(state), 32'(S_SOF));
        fv = 2'b11;
        wait_state(S_IMAGE, 3, "t1_enter_image");
        tick(3);
        fv = 2'b10;
        tick(1);
        check_eq("t1_image_hold", 32'(state), 32'(S_IMAGE));
        fv = 2'b00;
        wait_state(S_IDLE, 40, "t1_back_idle");
        tick(3);
        check_eq("t1_seq_hi", seq_acc[63:32], 32'h1);
        check_eq("t1_seq_lo", seq_acc[31:0], 32'h2345_6780);
        check_eq("t1_drain_len", dur[4], 4);
        check_eq("t1_meta_len", dur[5], 1);
        check_eq("t1_meta_wait_len", dur[6], 3);
        check_eq("t1_dma_len", dur[7], 1);
        check_eq("t1_rst_len", dur[8], 2);
        check_eq("t1_irq_count", irq_cnt, 1);
        check_eq("t1_frame_cnt", 32'(frame_cnt), 32'd1);
        check_eq("t1_cap_en", cap_err, 0);
        check_eq("t1_meta_flush_pulses", mf_cnt, 1);
        check_eq("t1_meta_en_cycles", me_cyc, 8);
        check_eq("t1_dma_flush_cycles", df_cyc, 1);
        check_eq("t1_cap_rst_cycles", cr_cyc, 2);
        check_eq("t1_aborted", 32'(aborted), 32'd0);

        // continuous: three full frames, stop during IMAGE of the fourth
        do_reset();
        clear_mon();
        continuous = 1'b1;
        cam_mask = 2'b11;
        start = 1'b1;
        wait_state(S_EOF, 5, "t2_enter_eof");
        start = 1'b0;
        for (int f = 0; f < 4; f++) begin
            wait_state(S_SOF, 40, "t2_sof");
            check_eq("t2_frame_cnt_at_sof", 32'(frame_cnt), f);
            fv = 2'b11;
            wait_state(S_IMAGE, 3, "t2_image");
            tick(2);
            if (f == 3) begin
                stop = 1'b1;
                wait_state(S_RST, 2, "t2_abort_to_rst");
            end else begin
                fv = 2'b00;
                wait_state(S_RST, 40, "t2_rst");
                wait_state(S_EOF, 5, "t2_rearm_eof");
            end
        end
        wait_state(S_IDLE, 5, "t2_final_idle");
        stop = 1'b0;
        fv = 2'b00;
        continuous = 1'b0;
        tick(3);
        check_eq("t2_frame_cnt", 32'(frame_cnt), 32'd3);
        check_eq("t2_aborted", 32'(aborted), 32'd1);
        check_eq("t2_irq_count", irq_cnt, 4);
        check_eq("t2_state_idle", 32'(state), 32'(S_IDLE));
        check_eq("t2_cap_en", cap_err, 0);

        // masked reference camera: SOF follows fv[1]; start held through RST restarts after one IDLE cycle
        do_reset();
        exp_mask = 2'b10;
        clear_mon();
        cam_mask = 2'b10;
        fv = 2'b01;
        start = 1'b1;
        wait_state(S_SOF, 5, "t3_enter_sof");
        tick(3);
        check_eq("t3_sof_ignores_cam0", 32'(state), 32'(S_SOF));
        fv = 2'b10;
        wait_state(S_IMAGE, 3, "t3_sof_from_cam1");
        tick(2);
        fv = 2'b01;
        wait_state(S_DRAIN, 2, "t3_drain");
        wait_state(S_IDLE, 40, "t3_idle");
        wait_state(S_EOF, 2, "t3_restart");
        tick(1);
        check_eq("t3_idle_len", dur[0], 1);
        check_eq("t3_frame_cnt", 32'(frame_cnt), 32'd1);
        check_eq("t3_cap_en", cap_err, 0);
        start = 1'b0;
        stop = 1'b1;
        wait_state(S_RST, 3, "t3_abort_rst");
        wait_state(S_IDLE, 5, "t3_abort_idle");
        stop = 1'b0;
        tick(3);
        check_eq("t3_aborted", 32'(aborted), 32'd1);
        check_eq("t3_irq_count", irq_cnt, 2);
        check_eq("t3_frame_cnt_after_abort", 32'(frame_cnt), 32'd1);

        // empty mask: start is ignored
        do_reset();
        clear_mon();
        cam_mask = 2'b00;
        start = 1'b1;
        tick(100);
        check_eq("t4_state", 32'(state), 32'(S_IDLE));
        check_eq("t4_busy_cycles", busy_cyc, 0);
        check_eq("t4_busy", 32'(busy), 32'd0);
        start = 1'b0;

        // stop ignored in DMA_FLUSH, then asynchronous reset mid-flush
        do_reset();
        exp_mask = 2'b11;
        cam_mask = 2'b11;
        dma_flush_complete = 1'b0;
        start = 1'b1;
        wait_state(S_EOF, 5, "t5_enter_eof");
        start = 1'b0;
        wait_state(S_SOF, 3, "t5_enter_sof");
        fv = 2'b11;
        wait_state(S_IMAGE, 3, "t5_enter_image");
        fv = 2'b00;
        wait_state(S_DMA_FLUSH, 40, "t5_enter_dma");
        stop = 1'b1;
        tick(3);
        check_eq("t5_stop_ignored", 32'(state), 32'(S_DMA_FLUSH));
        check_eq("t5_dma_flush", 32'(dma_flush), 32'd1);
        check_eq("t5_not_aborted", 32'(aborted), 32'd0);
        stop = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("t5_async_state", 32'(state), 32'(S_IDLE));
        check_eq("t5_async_outputs", out_vec(), 32'h0);
        tick(1);
        rst_n = 1'b1;
        dma_flush_complete = 1'b1;
        tick(3);
        check_eq("t5_idle_after_release", 32'(state), 32'(S_IDLE));
        check_eq("t5_outputs_after_release", out_vec(), 32'h0);

`ifdef CAPTURE_SEQ_WATCHDOG_EN
        // watchdog: DMA flush never completes
        do_reset();
        clear_mon();
        cam_mask = 2'b11;
        dma_flush_complete = 1'b0;
        start = 1'b1;
        wait_state(S_EOF, 5, "t6_enter_eof");
        start = 1'b0;
        wait_state(S_SOF, 3, "t6_enter_sof");
        fv = 2'b11;
        wait_state(S_IMAGE, 3, "t6_enter_image");
        fv = 2'b00;
        wait_state(S_DMA_FLUSH, 40, "t6_enter_dma");
        wait_state(S_RST, 300, "t6_watchdog_rst");
        tick(1);
        check_eq("t6_dma_len", dur[7], 255);
        check_eq("t6_timeout", 32'(timeout), 32'd1);
        wait_state(S_IDLE, 5, "t6_idle");
        tick(2);
        check_eq("t6_frame_cnt", 32'(frame_cnt), 32'd0);
        check_eq("t6_irq_count", irq_cnt, 1);
        dma_flush_complete = 1'b1;
`else
        check_eq("no_watchdog_timeout", 32'(timeout), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/capture_sequencer.md
# capture_sequencer

Parametrised frame-capture sequencer for the PCIe capture path, covering N_CAM imagers instead of a fixed pair. It runs one capture (or back-to-back captures) through these phases: end-of-frame, start-of-frame, image, pipeline drain, metadata, DMA flush and reset. It drives the capture enables, metadata and DMA flush strobes, the capture reset and the frame-done interrupt request. It also adds a camera mask, continuous mode, abort and a watchdog. All camera inputs are already synchronised to `c`.

## Interface
- `N_CAM`, 2: number of camera channels.
- `REF_CAM`, 0: index of the camera whose frame-valid defines start-of-frame.
- `DRAIN_CYCLES`, 256: dwell in DRAIN (corner-detector drain), range 1..2^CNT_W.
- `META_WAIT_CYCLES`, 32: dwell in META_WAIT, range 1..2^CNT_W.
- `RST_CYCLES`, 16: dwell in RST, range 1..2^CNT_W.
- `CNT_W`, 10: width of the dwell counter.
- `TO_W`, 24: width of the watchdog counter.
- `c`  in  1: clock (PCIe-side clock).
- `rst_n`  in  1: asynchronous active-low reset.
- `start`  in  1: level; begins a capture while in IDLE.
- `stop`  in  1: level; aborts any capture, or ends continuous mode.
- `continuous`  in  1: when high, re-arm after RST instead of returning to IDLE.
- `cam_mask`  in  N_CAM: cameras taking part; latched when leaving IDLE.
- `fv`  in  N_CAM: per-camera frame-valid, already synchronised.
- `metadata_flush_complete`  in  1: metadata unit has finished flushing.
- `dma_flush_complete`  in  1: DMA writer mux has finished flushing.
- `cap_en`  out  N_CAM: per-camera capture enable.
- `metadata_en`  out  1: gate on metadata output.
- `metadata_flush`  out  1: one-cycle pulse.
- `dma_flush`  out  1: DMA flush request.
- `cap_rst`  out  1: synchronous reset for capture machinery.
- `irq_set`  out  1: one-cycle capture-done pulse.
- `busy`  out  1: high when the state is not IDLE.
- `timeout`  out  1: sticky watchdog flag.
- `aborted`  out  1: sticky flag; the last capture was aborted by `stop`.
- `frame_cnt`  out  16: number of captures completed normally; wraps modulo 2^16.
- `state`  out  4: current state encoding.

## Operation
- States and encodings: IDLE=0, EOF=1, SOF=2, IMAGE=3, DRAIN=4, META=5, META_WAIT=6, DMA_FLUSH=7, RST=8. Any other encoding goes to IDLE on the next cycle.
- Let `m` be the latched mask, `all_low` = ~|(fv & m), and `ref` = fv[REF_CAM].
- IDLE → EOF when `start & ~stop & (|cam_mask)`.
  - On that transition, latch `cam_mask` into `m` and clear `timeout` and `aborted`.
  - `start` with an all-zero mask is ignored.
- EOF → SOF when `all_low`.
- SOF → IMAGE when `ref`. If REF_CAM is not in `m`, start-of-frame is taken from the lowest set bit of `m`.
- IMAGE → DRAIN when `all_low`.
- DRAIN → META after DRAIN_CYCLES cycles in DRAIN.
- META → META_WAIT when `metadata_flush_complete`.
- META_WAIT → DMA_FLUSH after META_WAIT_CYCLES cycles in META_WAIT.
- DMA_FLUSH → RST when `dma_flush_complete`.
- RST exit after RST_CYCLES cycles in RST:
  - to EOF if `continuous & ~stop & ~timeout & ~aborted`;
  - otherwise to IDLE.
- Abort: `stop` high in any of EOF, SOF, IMAGE, DRAIN or META_WAIT → RST next cycle, and `aborted` is set.
  - `stop` is ignored in META and DMA_FLUSH so that flushes in flight complete.
  - `stop` is ignored in RST.
- Dwell counter: cleared on every state change, increments each cycle while in the same state.
- Outputs are Moore decodes of the state register, registered one cycle:
  - `cap_en` = `m` in SOF and IMAGE, else 0;
  - `metadata_en` high in DRAIN, META and META_WAIT;
  - `metadata_flush` high on the first cycle in META only;
  - `dma_flush` high in DMA_FLUSH;
  - `cap_rst` high in RST.
- `irq_set` pulses for one cycle on every RST exit, including aborted and timed-out captures.
- `frame_cnt` increments on RST exit only when neither `aborted` nor `timeout` is set.

## Timing
- Asynchronous reset values: state IDLE; all outputs 0; `m` = 0; all counters 0.
- Transitions occur on the clock edge after the condition is seen. Registered outputs lag state entry by exactly 1 cycle.
- `irq_set` and the `frame_cnt` update appear 1 cycle after the RST-exit edge.
- Dwell states last exactly their parameter value in cycles. For example, DRAIN_CYCLES=256 gives 256 cycles in DRAIN.
- `metadata_flush_complete` arriving in the same cycle as META entry is honoured: META lasts 1 cycle.
- `start` held high through RST with `continuous` low: IDLE lasts 1 cycle, then a new capture begins.

## Configuration
- `CAPTURE_SEQ_WATCHDOG_EN` defined:
  - a TO_W-bit watchdog clears on every state change and counts in EOF, SOF, IMAGE, META and DMA_FLUSH;
  - at all-ones it forces RST next cycle and sets `timeout`.
- Undefined: no watchdog logic; `timeout` is tied to 0 and those states wait indefinitely.

## Test plan
- N_CAM=2, mask=2'b11, single frame, continuous=0:
  - state sequence 0,1,2,3,4,5,6,7,8,0;
  - `cap_en`=2'b11 only in SOF and IMAGE;
  - one `irq_set`;
  - `frame_cnt`=1.
- Continuous=1 for 3 frames, then `stop` asserted during IMAGE of frame 4:
  - `frame_cnt`=3;
  - `aborted`=1;
  - 4 `irq_set` pulses;
  - final state IDLE.
- mask=2'b10 with REF_CAM=0: SOF is taken from fv[1]; `cap_en`=2'b10.
- mask=0 with `start` high for 100 cycles: remains IDLE; `busy`=0.
- `rst_n` pulsed low mid-DMA_FLUSH: all outputs 0 asynchronously; IDLE after release.
- `CAPTURE_SEQ_WATCHDOG_EN` with TO_W=8 and `dma_flush_complete` never asserted:
  - RST entered 255 cycles after DMA_FLUSH entry;
  - `timeout`=1;
  - `frame_cnt` unchanged.
